pipeline_shutdown_controller: RTL
=================================

Name: pipeline_shutdown_controller

Overview:
- Orderly halt/resume sequencer for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
- On HALT_REQ: stops fetch, waits for each stage to drain front-to-back, then asserts that stage's reset.
- On RESUME_REQ: releases stage resets back-to-front (WB first) and re-enables fetch.
- Stage-reset outputs are active-low and are ANDed externally with the power-up reset sequencer's per-stage releases.

Parameters:
- DRAIN_TIMEOUT, 16, maximum cycles spent waiting on one stage before its reset is forced; legal range 2..255.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-low
- HALT_REQ  in  1  level halt request, sampled only in RUN
- RESUME_REQ  in  1  level resume request, sampled only in HALTED
- VLD_IF, VLD_ID, VLD_EXE, VLD_MEM, VLD_WB  in  1 each  stage holds a valid instruction
- RST_IF, RST_ID, RST_EXE, RST_MEM, RST_WB  out  1 each  stage reset, active-low (1 = stage running)
- FETCH_EN  out  1  instruction fetch enable
- HALT_ACK  out  1  pipeline fully halted
- BUSY  out  1  halt or resume sequence in progress
- TIMEOUT_FLAG  out  1  sticky: at least one stage reset was forced during the last drain

Behaviour:
- Clock and reset: CLK; RST synchronous, active-low.
- RST=0 at a rising edge:
  - state <= RUN; drain counter <= 0; TIMEOUT_FLAG <= 0.
  - Applies mid-sequence too; any drain or resume is abandoned.
- Outputs are Moore, decoded from state only, except TIMEOUT_FLAG, which is a register.
- States and outputs:
  - RUN: all RST_x=1, FETCH_EN=1, HALT_ACK=0, BUSY=0.
  - STOP: all RST_x=1, FETCH_EN=0, BUSY=1. Lasts exactly 1 cycle, then D_IF.
  - D_IF, D_ID, D_EXE, D_MEM, D_WB (drain states): FETCH_EN=0, BUSY=1. RST of every stage upstream of the current stage = 0; current and downstream = 1.
  - HALTED: all RST_x=0, FETCH_EN=0, HALT_ACK=1, BUSY=0.
  - R_WB, R_MEM, R_EXE, R_ID, R_IF (resume states): FETCH_EN=0, BUSY=1. RST=1 for the named stage and every stage downstream of it; 0 upstream. In R_IF all RST_x=1.
- Transitions:
  - RUN -> STOP when HALT_REQ=1.
  - STOP -> D_IF unconditionally.
  - D_s -> next drain state (D_WB -> HALTED) when VLD_s=0 OR cnt=DRAIN_TIMEOUT-1.
  - HALTED -> R_WB when RESUME_REQ=1.
  - R_WB -> R_MEM -> R_EXE -> R_ID -> R_IF -> RUN, one cycle each, unconditional.
- Drain counter:
  - 8 bits; cleared on entry to every drain state; increments each cycle while the stage waits.
  - Saturation is not needed because the timeout exit precedes wrap.
- Timeout:
  - Exit taken with VLD_s=1 (exit by timeout only) sets TIMEOUT_FLAG=1 at the same edge.
  - If VLD_s=0 on the timeout cycle, the exit counts as normal and the flag is not set.
  - TIMEOUT_FLAG is cleared on the RUN->STOP transition (start of a new halt) and by RST; it holds through HALTED and resume.
- Simultaneous and ignored events:
  - HALT_REQ and RESUME_REQ both high in RUN: halt taken; RESUME_REQ ignored.
  - RESUME_REQ outside HALTED: ignored.
  - HALT_REQ outside RUN: ignored.
  - HALT_REQ held high through a resume: STOP is entered on the cycle after RUN is reached (RUN lasts exactly 1 cycle with FETCH_EN=1).
- Latency:
  - Halt with all stages empty: HALT_ACK rises 7 cycles after the edge sampling HALT_REQ.
  - Resume: FETCH_EN rises 6 cycles after the edge sampling RESUME_REQ.

Test Plan:
- Empty drain: RST released, all VLD=0, HALT_REQ=1 for 1 cycle sampled at edge 0.
  - FETCH_EN=0 from cycle 1; RST_IF=0 at cycle 3; RST_ID=0 at 4; RST_EXE=0 at 5; RST_MEM=0 at 6.
  - Cycle 7: all RST_x=0, HALT_ACK=1, BUSY=0, TIMEOUT_FLAG=0.
- Stalled stage: VLD_EXE=1 for 3 cycles after entering D_EXE, other VLD=0.
  - D_EXE lasts 4 cycles; HALT_ACK at cycle 10; TIMEOUT_FLAG=0.
- Timeout: DRAIN_TIMEOUT=4, VLD_MEM held 1.
  - D_MEM lasts exactly 4 cycles; RST_MEM forced 0; TIMEOUT_FLAG=1 and stays 1 in HALTED.
- Resume: from HALTED, RESUME_REQ sampled at edge 0.
  - Cycle 1: RST_WB=1 only; cycle 2 adds RST_MEM; cycle 3 RST_EXE; cycle 4 RST_ID; cycle 5 RST_IF.
  - Cycle 6: RUN, FETCH_EN=1, HALT_ACK=0.
- Priority and ignore: HALT_REQ=RESUME_REQ=1 in RUN -> STOP entered. RESUME_REQ pulsed during D_ID -> no effect, halt completes normally.
- Reset mid-sequence: RST=0 while in D_MEM (RST_IF/ID/EXE=0) -> next cycle all RST_x=1, FETCH_EN=1, BUSY=0, TIMEOUT_FLAG=0.

Source files
------------

// File: rtl/pipeline_shutdown_if.sv
// Halt/resume request, per-stage valid and per-stage reset signals of the
// pipeline shutdown controller.
interface pipeline_shutdown_if;
  logic HALT_REQ;
  logic RESUME_REQ;
  logic VLD_IF;
  logic VLD_ID;
  logic VLD_EXE;
  logic VLD_MEM;
  logic VLD_WB;
  logic RST_IF;
  logic RST_ID;
  logic RST_EXE;
  logic RST_MEM;
  logic RST_WB;
  logic FETCH_EN;
  logic HALT_ACK;
  logic BUSY;
  logic TIMEOUT_FLAG;

  modport master (
    input  HALT_REQ, RESUME_REQ,
    input  VLD_IF, VLD_ID, VLD_EXE, VLD_MEM, VLD_WB,
    output RST_IF, RST_ID, RST_EXE, RST_MEM, RST_WB,
    output FETCH_EN, HALT_ACK, BUSY, TIMEOUT_FLAG
  );

  modport slave (
    output HALT_REQ, RESUME_REQ,
    output VLD_IF, VLD_ID, VLD_EXE, VLD_MEM, VLD_WB,
    input  RST_IF, RST_ID, RST_EXE, RST_MEM, RST_WB,
    input  FETCH_EN, HALT_ACK, BUSY, TIMEOUT_FLAG
  );
endinterface

// File: rtl/pipeline_shutdown_controller.sv
// Orderly halt/resume sequencer for the 5-stage pipeline: drains stages
// front-to-back into reset, then releases them back-to-front on resume.
module pipeline_shutdown_controller #(
  parameter int unsigned DRAIN_TIMEOUT = 16
) (
  input logic                   CLK,
  input logic                   RST,
  pipeline_shutdown_if.master   bus
);

  localparam logic [7:0] CntLast = 8'(DRAIN_TIMEOUT - 1);

  typedef enum logic [3:0] {
    StRun, StStop,
    StDIf, StDId, StDExe, StDMem, StDWb,
    StHalted,
    StRWb, StRMem, StRExe, StRId, StRIf
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       flag_q, flag_d;

  logic       in_drain;
  logic       cur_vld;
  state_e     drain_next;
  logic [4:0] rst_n;  // bit 0 = IF ... bit 4 = WB
  logic       fetch_en;
  logic       halt_ack;
  logic       busy;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StRun;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  // Which stage is being drained and where to go once it is empty.
  always_comb begin
    in_drain   = 1'b0;
    cur_vld    = 1'b0;
    drain_next = StHalted;
    unique case (state_q)
      StDIf:  begin in_drain = 1'b1; cur_vld = bus.VLD_IF;  drain_next = StDId;    end
      StDId:  begin in_drain = 1'b1; cur_vld = bus.VLD_ID;  drain_next = StDExe;   end
      StDExe: begin in_drain = 1'b1; cur_vld = bus.VLD_EXE; drain_next = StDMem;   end
      StDMem: begin in_drain = 1'b1; cur_vld = bus.VLD_MEM; drain_next = StDWb;    end
      StDWb:  begin in_drain = 1'b1; cur_vld = bus.VLD_WB;  drain_next = StHalted; end
      default: begin end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    flag_d  = flag_q;
    if (in_drain) begin
      if (!cur_vld || cnt_q == CntLast) begin
        state_d = drain_next;
        // Only a stage still holding work when time runs out counts as forced.
        if (cur_vld) flag_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.HALT_REQ) begin
            state_d = StStop;
            flag_d  = 1'b0;
          end
        end
        StStop:   state_d = StDIf;
        StHalted: if (bus.RESUME_REQ) state_d = StRWb;
        StRWb:    state_d = StRMem;
        StRMem:   state_d = StRExe;
        StRExe:   state_d = StRId;
        StRId:    state_d = StRIf;
        StRIf:    state_d = StRun;
        default:  state_d = StRun;
      endcase
    end
  end

  always_comb begin
    rst_n    = 5'b11111;
    fetch_en = 1'b0;
    halt_ack = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      StRun: begin
        fetch_en = 1'b1;
        busy     = 1'b0;
      end
      StStop, StDIf, StRIf: begin end
      StDId, StRId:   rst_n = 5'b11110;
      StDExe, StRExe: rst_n = 5'b11100;
      StDMem, StRMem: rst_n = 5'b11000;
      StDWb, StRWb:   rst_n = 5'b10000;
      StHalted: begin
        rst_n    = 5'b00000;
        halt_ack = 1'b1;
        busy     = 1'b0;
      end
      default: begin end
    endcase
  end

  assign bus.RST_IF       = rst_n[0];
  assign bus.RST_ID       = rst_n[1];
  assign bus.RST_EXE      = rst_n[2];
  assign bus.RST_MEM      = rst_n[3];
  assign bus.RST_WB       = rst_n[4];
  assign bus.FETCH_EN     = fetch_en;
  assign bus.HALT_ACK     = halt_ack;
  assign bus.BUSY         = busy;
  assign bus.TIMEOUT_FLAG = flag_q;

endmodule
